// File: rtl/pattern_recorder_pkg.sv
// Shared widths, table size and FSM state encoding for the pattern recorder.
package pattern_recorder_pkg;

   localparam int PAT_W  = 10;
   localparam int DEPTH  = 44;
   localparam int ADDR_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Decimal digit increment, 9 wraps to 0.
   function automatic logic [3:0] digit_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/pattern_recorder_key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, down-counter
// debounce, one-cycle pulse on an accepted press (1->0). Release is silent.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic key_n_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q, sync2_q;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   // Synchronise the raw key; idle level is released (high).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync2_q == acc_q) begin
         cnt_d = CNT_RELOAD;
      end else if (cnt_q == '0) begin
         acc_d   = sync2_q;
         cnt_d   = CNT_RELOAD;
         press_d = ~sync2_q;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q   <= 1'b1;
         cnt_q   <= CNT_RELOAD;
         press_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/pattern_recorder.sv
// Write side of the LED pattern table: captures switch patterns on CAPTURE,
// closes the recording on DONE, exposes entries on a registered read port.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  ST_IDLE    | empty; first CAPTURE writes entry 0 and starts recording
//  ST_RECORD  | appending entries; DONE or a full table closes it
//  ST_DONE    | recording closed, pat_len valid; DONE returns to IDLE
module pattern_recorder
   import pattern_recorder_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic              clk_50mhz,
   input  logic              reset,
   input  logic [PAT_W-1:0]  sw_pattern,
   input  logic              key_capture_n,
   input  logic              key_done_n,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PAT_W-1:0]  rd_data,
   output logic [ADDR_W-1:0] pat_len,
   output logic              rec_busy,
   output logic              rec_done,
   output logic              rec_full,
   output logic [PAT_W-1:0]  led_echo,
   output logic [3:0]        count_digit
);

   logic [PAT_W-1:0]  sw_s1_q, sw_s2_q;
   logic              cap_p, done_p;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] pat_len_q, pat_len_d;
   logic [3:0]        count_q, count_d;
   logic              full_q, full_d;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;

   logic [PAT_W-1:0]  mem_q [DEPTH];
   logic [PAT_W-1:0]  rd_data_q;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cap_db (
      .clk_i   (clk_50mhz),
      .reset_i (reset),
      .key_n_i (key_capture_n),
      .press_o (cap_p)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_done_db (
      .clk_i   (clk_50mhz),
      .reset_i (reset),
      .key_n_i (key_done_n),
      .press_o (done_p)
   );

   // Synchronise the switches; the second stage is both the preview and the captured value.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         sw_s1_q <= sw_pattern;
         sw_s2_q <= sw_s1_q;
      end
   end

   // Recording FSM next state, table write enable and bookkeeping.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      pat_len_d = pat_len_q;
      count_d   = count_q;
      full_d    = full_q;
      we        = 1'b0;
      wr_addr   = wr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (cap_p) begin
               we       = 1'b1;
               wr_addr  = '0;
               wr_ptr_d = ADDR_W'(1);
               count_d  = 4'd1;
               state_d  = ST_RECORD;
            end
         end
         ST_RECORD: begin
            if (cap_p) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               count_d  = digit_inc(count_q);
               if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  full_d    = 1'b1;
                  pat_len_d = ADDR_W'(DEPTH);
                  state_d   = ST_DONE;
               end else if (done_p) begin
                  // Coincident DONE closes after including this entry.
                  pat_len_d = wr_ptr_q + ADDR_W'(1);
                  state_d   = ST_DONE;
               end
            end else if (done_p) begin
               pat_len_d = wr_ptr_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (done_p) begin
               wr_ptr_d  = '0;
               pat_len_d = '0;
               count_d   = '0;
               full_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and bookkeeping registers.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         pat_len_q <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         pat_len_q <= pat_len_d;
         count_q   <= count_d;
         full_q    <= full_d;
      end
   end

   // Table write port; contents deliberately survive reset.
   always_ff @(posedge clk_50mhz) begin
      if (we) mem_q[wr_addr] <= sw_s2_q;
   end

   // Registered read port; out-of-range addresses read as zero, same-address write returns old data.
   always_ff @(posedge clk_50mhz) begin
      if (reset)                          rd_data_q <= '0;
      else if (rd_addr < ADDR_W'(DEPTH))  rd_data_q <= mem_q[rd_addr];
      else                                rd_data_q <= '0;
   end

   assign rd_data     = rd_data_q;
   assign pat_len     = pat_len_q;
   assign rec_busy    = (state_q == ST_RECORD);
   assign rec_done    = (state_q == ST_DONE);
   assign rec_full    = full_q;
   assign led_echo    = sw_s2_q;
   assign count_digit = count_q;

endmodule

// File: tb/tb_pattern_recorder.sv
// Bench for pattern_recorder: hand-computed vector table, directed corner
// sequences and randomised actions checked against a behavioural model.
module tb_pattern_recorder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] sw_pattern = '0;
   logic       key_capture_n = 1'b1;
   logic       key_done_n = 1'b1;
   logic [5:0] rd_addr = '0;
   logic [9:0] rd_data;
   logic [5:0] pat_len;
   logic       rec_busy, rec_done, rec_full;
   logic [9:0] led_echo;
   logic [3:0] count_digit;

   int n_chk = 0;
   int n_fail = 0;

   // Behavioural model: mode 0 idle, 1 recording, 2 closed.
   int         m_mode = 0;
   int         m_n = 0;
   int         m_len = 0;
   bit         m_full = 0;
   logic [9:0] m_mem [44];
   bit         m_known [44];

   always #10 clk = ~clk;

   pattern_recorder #(.DEBOUNCE_CYC(4)) dut (
      .clk_50mhz     (clk),
      .reset         (reset),
      .sw_pattern    (sw_pattern),
      .key_capture_n (key_capture_n),
      .key_done_n    (key_done_n),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .pat_len       (pat_len),
      .rec_busy      (rec_busy),
      .rec_done      (rec_done),
      .rec_full      (rec_full),
      .led_echo      (led_echo),
      .count_digit   (count_digit)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_capture(input logic [9:0] sw);
      if (m_mode == 0) begin
         m_mem[0] = sw; m_known[0] = 1; m_n = 1; m_mode = 1;
      end else if (m_mode == 1) begin
         m_mem[m_n] = sw; m_known[m_n] = 1; m_n++;
         if (m_n == 44) begin m_full = 1; m_len = 44; m_mode = 2; end
      end
   endtask

   task automatic model_done();
      if (m_mode == 1) begin
         m_len = m_n; m_mode = 2;
      end else if (m_mode == 2) begin
         m_mode = 0; m_n = 0; m_len = 0; m_full = 0;
      end
   endtask

   task automatic model_both(input logic [9:0] sw);
      if (m_mode == 0) model_capture(sw);
      else if (m_mode == 1) begin
         model_capture(sw);
         if (m_mode == 1) begin m_len = m_n; m_mode = 2; end
      end else model_done();
   endtask

   // Press one or both keys cleanly with the switches already settled.
   task automatic press(input bit cap, input bit dn, input logic [9:0] sw);
      @(negedge clk); sw_pattern = sw;
      repeat (3) @(negedge clk);
      key_capture_n = ~cap; key_done_n = ~dn;
      repeat (12) @(negedge clk);
      key_capture_n = 1'b1; key_done_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic act(input int kind, input logic [9:0] sw);
      case (kind)
         0: begin press(1, 0, sw); model_capture(sw); end
         1: begin press(0, 1, sw); model_done(); end
         default: begin press(1, 1, sw); model_both(sw); end
      endcase
   endtask

   task automatic do_read(input logic [5:0] a, output logic [9:0] d);
      @(negedge clk); rd_addr = a;
      @(posedge clk); #1;
      d = rd_data;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " busy"},  32'(rec_busy),    32'(m_mode == 1));
      chk({tag, " done"},  32'(rec_done),    32'(m_mode == 2));
      chk({tag, " full"},  32'(rec_full),    32'(m_full));
      chk({tag, " len"},   32'(pat_len),     32'(m_len));
      chk({tag, " count"}, 32'(count_digit), 32'(m_n % 10));
   endtask

   task automatic check_read(input string tag, input logic [5:0] a);
      logic [9:0] d;
      do_read(a, d);
      if (a >= 44) chk({tag, " rd_oob"}, 32'(d), 32'h0);
      else if (m_known[a]) chk($sformatf("%s rd[%0d]", tag, a), 32'(d), 32'(m_mem[a]));
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1; key_capture_n = 1'b1; key_done_n = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      m_mode = 0; m_n = 0; m_len = 0; m_full = 0;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      int         kind;   // 0 cap, 1 done, 2 both, 3 read
      logic [9:0] sw;
      logic [5:0] addr;
      logic       busy;
      logic       done;
      logic [5:0] len;
      logic [3:0] cnt;
      logic [9:0] rd;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [9:0] d;
      tbl[0]  = '{0, 10'h030, 6'd0,  1'b1, 1'b0, 6'd0, 4'd1, 10'h000};
      tbl[1]  = '{3, 10'h000, 6'd0,  1'b1, 1'b0, 6'd0, 4'd1, 10'h030};
      tbl[2]  = '{0, 10'h078, 6'd0,  1'b1, 1'b0, 6'd0, 4'd2, 10'h000};
      tbl[3]  = '{0, 10'h0FC, 6'd0,  1'b1, 1'b0, 6'd0, 4'd3, 10'h000};
      tbl[4]  = '{1, 10'h000, 6'd0,  1'b0, 1'b1, 6'd3, 4'd3, 10'h000};
      tbl[5]  = '{3, 10'h000, 6'd2,  1'b0, 1'b1, 6'd3, 4'd3, 10'h0FC};
      tbl[6]  = '{3, 10'h000, 6'd50, 1'b0, 1'b1, 6'd3, 4'd3, 10'h000};
      tbl[7]  = '{3, 10'h000, 6'd1,  1'b0, 1'b1, 6'd3, 4'd3, 10'h078};
      tbl[8]  = '{0, 10'h155, 6'd0,  1'b0, 1'b1, 6'd3, 4'd3, 10'h000};
      tbl[9]  = '{1, 10'h000, 6'd0,  1'b0, 1'b0, 6'd0, 4'd0, 10'h000};
      tbl[10] = '{1, 10'h000, 6'd0,  1'b0, 1'b0, 6'd0, 4'd0, 10'h000};

      // Reset values while reset is held with non-zero switches.
      sw_pattern = 10'h3FF;
      repeat (4) @(negedge clk);
      chk("rst rd_data", 32'(rd_data), 0);
      chk("rst pat_len", 32'(pat_len), 0);
      chk("rst busy", 32'(rec_busy), 0);
      chk("rst done", 32'(rec_done), 0);
      chk("rst full", 32'(rec_full), 0);
      chk("rst led_echo", 32'(led_echo), 0);
      chk("rst count", 32'(count_digit), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("led_echo live", 32'(led_echo), 32'h3FF);

      // Vector table.
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].kind == 3) begin
            do_read(tbl[i].addr, d);
            chk($sformatf("tbl%0d rd", i), 32'(d), 32'(tbl[i].rd));
         end else begin
            act(tbl[i].kind, tbl[i].sw);
         end
         chk($sformatf("tbl%0d busy", i), 32'(rec_busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d done", i), 32'(rec_done), 32'(tbl[i].done));
         chk($sformatf("tbl%0d len", i), 32'(pat_len), 32'(tbl[i].len));
         chk($sformatf("tbl%0d cnt", i), 32'(count_digit), 32'(tbl[i].cnt));
      end

      // Bouncing CAPTURE yields exactly one entry; next capture lands at index 1.
      do_reset();
      @(negedge clk); sw_pattern = 10'h2A5;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         key_capture_n = (i % 2 == 1);
         repeat (2) @(negedge clk);
      end
      key_capture_n = 1'b0;
      repeat (12) @(negedge clk);
      key_capture_n = 1'b1;
      repeat (12) @(negedge clk);
      model_capture(10'h2A5);
      chk("bounce count", 32'(count_digit), 1);
      chk("bounce busy", 32'(rec_busy), 1);
      act(0, 10'h111);
      check_read("bounce", 6'd0);
      check_read("bounce", 6'd1);
      check_model("bounce");

      // Fill all 44 entries, then an ignored 45th capture.
      do_reset();
      for (int i = 0; i < 44; i++) act(0, 10'((i * 37 + 5) & 10'h3FF));
      chk("full flag", 32'(rec_full), 1);
      chk("full len", 32'(pat_len), 44);
      chk("full done", 32'(rec_done), 1);
      chk("full count", 32'(count_digit), 4);
      act(0, 10'h3C3);
      chk("full 45th count", 32'(count_digit), 4);
      for (int a = 0; a < 44; a++) check_read("full", 6'(a));
      check_model("full after");

      // Coincident CAPTURE and DONE after two entries.
      do_reset();
      act(0, 10'h001);
      act(0, 10'h002);
      act(2, 10'h2C4);
      chk("both len", 32'(pat_len), 3);
      chk("both done", 32'(rec_done), 1);
      chk("both count", 32'(count_digit), 3);
      do_read(6'd2, d);
      chk("both rd2", 32'(d), 32'h2C4);

      // Reset mid-recording keeps memory; DONE in DONE returns to IDLE.
      do_reset();
      for (int i = 0; i < 5; i++) act(0, 10'(10'h100 + i * 3));
      do_reset();
      chk("midrst busy", 32'(rec_busy), 0);
      chk("midrst len", 32'(pat_len), 0);
      chk("midrst count", 32'(count_digit), 0);
      do_read(6'd4, d);
      chk("midrst mem4", 32'(d), 32'h10C);
      act(1, 10'h0);
      chk("idle done ignored", 32'(rec_done), 0);
      act(0, 10'h0AA);
      act(1, 10'h0);
      chk("close len", 32'(pat_len), 1);
      act(1, 10'h0);
      chk("reopen done", 32'(rec_done), 0);
      chk("reopen len", 32'(pat_len), 0);

      // Randomised actions against the model.
      do_reset();
      for (int i = 0; i < 90; i++) begin
         int r;
         r = $urandom_range(0, 11);
         if (r <= 6) act(0, 10'($urandom));
         else if (r == 7) act(1, 10'($urandom));
         else if (r == 8) act(2, 10'($urandom));
         else if (r == 9) begin
            @(negedge clk); sw_pattern = 10'($urandom);
            d = sw_pattern;
            repeat (3) @(negedge clk);
            chk("rand led_echo", 32'(led_echo), 32'(d));
         end else check_read("rand", 6'($urandom_range(0, 63)));
         check_model($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
